multicycle_ctrl_ws: RTL

Parametrised, wait-state-aware main control FSM for the multicycle MIPS datapath. It supersedes the fixed-latency control unit with these additions:
- Memory request/ready handshake with a timeout.
- Immediate-logic, SLT-immediate and JAL instructions.
- Sticky trap reporting for illegal opcodes and memory timeouts.
- Fully specified (latch-free) outputs in every state.

It sits between the instruction register opcode field and the datapath/memory enables.

---
 rtl/mc_ctrl_pkg.sv | 43 ++++
 rtl/mc_wait_timer.sv | 18 +
 rtl/multicycle_ctrl_ws.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state, opcode, control-field and trap-cause encodings for multicycle_ctrl_ws
package mc_ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MADDR, MRD, MWB, MWR, REXE, RWB,
    BEQ, BNE, IEXE, IWB, JMP, JAL, TRAP
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;
  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;
  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_ILL  = 2'b01;
  localparam logic [1:0] CAUSE_TMO  = 2'b10;
  function automatic logic is_wait(state_t s);
    return s == FETCH || s == MRD || s == MWR;
  endfunction
endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: memory wait-cycle counter with timeout compare
module mc_wait_timer #(
  parameter int TIMEOUT_W   = 4,
  parameter int MEM_TIMEOUT = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic timeout
);
  logic [TIMEOUT_W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + TIMEOUT_W'(1);
  assign timeout = cnt == TIMEOUT_W'(MEM_TIMEOUT);
endmodule

// File: rtl/multicycle_ctrl_ws.sv
// multicycle_ctrl_ws: wait-state-aware multicycle MIPS main control FSM with sticky traps
module multicycle_ctrl_ws
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W        = 6,
  parameter int ALUOP_W     = 3,
  parameter int TIMEOUT_W   = 4,
  parameter int MEM_TIMEOUT = 12,
  parameter bit ENABLE_JAL  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    op,
  input  logic               mem_ready,
  input  logic               trap_clr,
  output logic               mem_req,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic               PCWrite,
  output logic               BeQ,
  output logic               BnE,
  output logic               ImmZext,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemToReg,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUop,
  output logic [1:0]         PCSrc,
  output logic               trap,
  output logic [1:0]         trap_cause,
  output logic [3:0]         state_o
);
  state_t state, nxt;
  logic [5:0] opc;
  logic [2:0] alu;
  logic tmo;
  assign opc = op[5:0];
  assign state_o = state;
  assign ALUop = ALUOP_W'(alu);
  mc_wait_timer #(.TIMEOUT_W(TIMEOUT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk(clk), .rst(rst), .en(is_wait(state) && !mem_ready), .clr(nxt != state), .timeout(tmo)
  );
  always_comb begin
    nxt = state;
    case (state)
      FETCH:  nxt = mem_ready ? DECODE : tmo ? TRAP : FETCH;
      DECODE:
        case (opc)
          OP_LW, OP_SW:                       nxt = MADDR;
          OP_RTYPE:                           nxt = REXE;
          OP_BEQ:                             nxt = BEQ;
          OP_BNE:                             nxt = BNE;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  nxt = IEXE;
          OP_J:                               nxt = JMP;
          OP_JAL:                             nxt = ENABLE_JAL ? JAL : TRAP;
          default:                            nxt = TRAP;
        endcase
      MADDR:  nxt = opc == OP_SW ? MWR : MRD;
      MRD:    nxt = mem_ready ? MWB : tmo ? TRAP : MRD;
      MWR:    nxt = mem_ready ? FETCH : tmo ? TRAP : MWR;
      REXE:   nxt = RWB;
      IEXE:   nxt = IWB;
      TRAP:   nxt = trap_clr ? FETCH : TRAP;
      default: nxt = FETCH;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= FETCH;
      trap <= 1'b0;
      trap_cause <= CAUSE_NONE;
    end else begin
      state <= nxt;
      if (state == TRAP) begin
        if (trap_clr) begin
          trap <= 1'b0;
          trap_cause <= CAUSE_NONE;
        end
      end else if (nxt == TRAP) begin
        trap <= 1'b1;
        trap_cause <= state == DECODE ? CAUSE_ILL : CAUSE_TMO;
      end
    end
  // Outputs are held at zero while rst is high so an aborted access issues no strobe.
  always_comb begin
    {mem_req, MemWrite, IRWrite, RegWrite, ALUSrcA, PCWrite, BeQ, BnE, ImmZext} = '0;
    RegDst = RD_RT;
    MemToReg = M2R_ALU;
    ALUSrcB = SRCB_B;
    alu = ALU_ADD;
    PCSrc = PC_ALU;
    if (!rst)
      case (state)
        FETCH: begin
          mem_req = 1'b1;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
          ALUSrcB = SRCB_4;
        end
        DECODE: ALUSrcB = SRCB_IMM2;
        MADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        MRD: mem_req = 1'b1;
        MWB: begin
          MemToReg = M2R_MDR;
          RegWrite = 1'b1;
        end
        MWR: begin
          mem_req = 1'b1;
          MemWrite = 1'b1;
        end
        REXE: begin
          ALUSrcA = 1'b1;
          alu = ALU_FUNCT;
        end
        RWB: begin
          RegDst = RD_RD;
          RegWrite = 1'b1;
        end
        BEQ, BNE: begin
          ALUSrcA = 1'b1;
          alu = ALU_SUB;
          PCSrc = PC_ALUOUT;
          BeQ = state == BEQ;
          BnE = state == BNE;
        end
        IEXE: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          alu = opc == OP_ANDI ? ALU_AND : opc == OP_ORI ? ALU_OR : opc == OP_SLTI ? ALU_SLT : ALU_ADD;
          ImmZext = opc == OP_ANDI || opc == OP_ORI;
        end
        IWB: RegWrite = 1'b1;
        JMP: begin
          PCSrc = PC_JUMP;
          PCWrite = 1'b1;
        end
        JAL: begin
          RegDst = RD_RA;
          MemToReg = M2R_PC;
          RegWrite = 1'b1;
          PCSrc = PC_JUMP;
          PCWrite = 1'b1;
        end
        default: ;
      endcase
  end
endmodule
